// File: rtl/systolic_feeder.sv
// systolic_feeder: skews A/B slices onto the edges of an MxM systolic array and sequences enable, clear and done
module systolic_feeder #(
  parameter int N = 32,
  parameter int M = 8,
  parameter int K_MAX = 256,
  localparam int KW = $clog2(K_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KW-1:0]       k_len,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [M-1:0][N-1:0] a_col,
  input  logic [M-1:0][N-1:0] b_row,
  output logic [M-1:0][N-1:0] arr_x,
  output logic [M-1:0][N-1:0] arr_y,
  output logic                arr_en,
  output logic                acc_clr,
  output logic                busy,
  output logic                done
);
  localparam int FW = $clog2(2 * M);
  localparam logic [FW-1:0] F_LAST = FW'(2 * M - 2);
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;
  state_t st, nxt;
  logic [KW-1:0] klen_r, kcnt, k_sat;
  logic [FW-1:0] fcnt;
  logic acc;
  logic [M-1:0][N-1:0] fa, fb;
  assign k_sat = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  always_ff @(posedge clk)
    if (rst) begin
      st     <= IDLE;
      klen_r <= '0;
      kcnt   <= '0;
      fcnt   <= '0;
    end else begin
      st   <= nxt;
      if (acc_clr) klen_r <= k_sat;
      kcnt <= (st == DONE) ? '0 : kcnt + KW'(acc);
      fcnt <= (st == FLUSH) ? fcnt + FW'(1) : '0;
    end
  always_comb begin
    nxt = st == IDLE   ? (start ? (k_sat != '0 ? STREAM : DONE) : IDLE)
        : st == STREAM ? ((acc && kcnt == klen_r - KW'(1)) ? FLUSH : STREAM)
        : st == FLUSH  ? (fcnt == F_LAST ? DONE : FLUSH)
        : IDLE;
  end
  always_comb begin
    s_ready = st == STREAM;
    acc     = s_valid && st == STREAM;
    arr_en  = acc || st == FLUSH;
    acc_clr = start && st == IDLE;
    busy    = st != IDLE;
    done    = st == DONE;
  end
  assign fa = (st == STREAM) ? a_col : '0;
  assign fb = (st == STREAM) ? b_row : '0;
  for (genvar i = 0; i < M; i++) begin : g_lane
    localparam int W = (i + 1) * N;
    logic [W-1:0] xd, yd;
    always_ff @(posedge clk)
      if (rst) begin
        xd <= '0;
        yd <= '0;
      end else if (arr_en) begin
        xd <= W'({xd, fa[i]});
        yd <= W'({yd, fb[i]});
      end
    assign arr_x[i] = xd[W-1 -: N];
    assign arr_y[i] = yd[W-1 -: N];
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: scoreboard bench for systolic_feeder at M=2 (directed products) and M=8 (skew model)
module tb_systolic_feeder;
  localparam int N = 32;
  typedef logic [1:0][N-1:0] fr2_t;
  typedef logic [7:0][N-1:0] fr8_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic st2 = 0, v2 = 0, r2, en2, clr2, busy2, done2;
  logic [8:0] kl2 = '0;
  fr2_t a2 = '0, b2 = '0, x2, y2;
  logic st8 = 0, v8 = 0, r8, en8, clr8, busy8, done8;
  logic [8:0] kl8 = '0;
  fr8_t a8 = '0, b8 = '0, x8, y8;
  systolic_feeder #(.N(N), .M(2), .K_MAX(256)) u2 (
    .clk(clk), .rst(rst), .start(st2), .k_len(kl2), .s_valid(v2), .s_ready(r2),
    .a_col(a2), .b_row(b2), .arr_x(x2), .arr_y(y2), .arr_en(en2), .acc_clr(clr2),
    .busy(busy2), .done(done2));
  systolic_feeder #(.N(N), .M(8), .K_MAX(256)) u8 (
    .clk(clk), .rst(rst), .start(st8), .k_len(kl8), .s_valid(v8), .s_ready(r8),
    .a_col(a8), .b_row(b8), .arr_x(x8), .arr_y(y8), .arr_en(en8), .acc_clr(clr8),
    .busy(busy8), .done(done8));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  logic signed [N-1:0] px[2][2], py[2][2], xin[2][2], yin[2][2];
  longint acc[2][2];
  assign xin[0][0] = x2[0];
  assign xin[0][1] = px[0][0];
  assign xin[1][0] = x2[1];
  assign xin[1][1] = px[1][0];
  assign yin[0][0] = y2[0];
  assign yin[0][1] = y2[1];
  assign yin[1][0] = py[0][0];
  assign yin[1][1] = py[0][1];
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (rst || clr2) begin
          acc[i][j] <= 0;
          px[i][j] <= '0;
          py[i][j] <= '0;
        end else if (en2) begin
          acc[i][j] <= acc[i][j] + longint'(xin[i][j]) * longint'(yin[i][j]);
          px[i][j] <= xin[i][j];
          py[i][j] <= yin[i][j];
        end
  fr2_t qx2[$], qy2[$];
  fr2_t lx2 = '0, ly2 = '0, ex2, ey2;
  int qd2[$];
  longint qacc[$];
  logic en2_p = 0, rst_p = 0;
  int nclr2 = 0, nen2 = 0, nrdy2 = 0;
  always @(negedge clk) begin
    if (rst_p) begin
      lx2 = '0;
      ly2 = '0;
      chk("rst_x2", x2, 0);
      chk("rst_y2", y2, 0);
      chk("rst_busy2", busy2, 0);
      chk("rst_en2", en2, 0);
      chk("rst_done2", done2, 0);
      chk("rst_rdy2", r2, 0);
    end else if (en2_p) begin
      chk("sb2_avail", qx2.size() != 0, 1);
      if (qx2.size() != 0) begin
        ex2 = qx2.pop_front();
        ey2 = qy2.pop_front();
        chk("x2_frame", x2, ex2);
        chk("y2_frame", y2, ey2);
        lx2 = ex2;
        ly2 = ey2;
      end
    end else begin
      chk("x2_hold", x2, lx2);
      chk("y2_hold", y2, ly2);
    end
    if (done2) begin
      chk("done2_expected", qd2.size() != 0, 1);
      if (qd2.size() != 0) chk("done2_cyc", cyc, qd2.pop_front());
      if (qacc.size() >= 4) begin
        chk("acc00", acc[0][0], qacc.pop_front());
        chk("acc01", acc[0][1], qacc.pop_front());
        chk("acc10", acc[1][0], qacc.pop_front());
        chk("acc11", acc[1][1], qacc.pop_front());
      end
    end
    nclr2 += int'(clr2);
    nen2 += int'(en2);
    nrdy2 += int'(r2);
    rst_p = rst;
    en2_p = en2;
  end
  fr8_t qx8[$], qy8[$], ex8, ey8;
  int qd8[$];
  logic en8_p = 0;
  always @(negedge clk) begin
    if (en8_p) begin
      chk("sb8_avail", qx8.size() != 0, 1);
      if (qx8.size() != 0) begin
        ex8 = qx8.pop_front();
        ey8 = qy8.pop_front();
        for (int i = 0; i < 8; i++) begin
          chk($sformatf("x8_lane%0d", i), x8[i], ex8[i]);
          chk($sformatf("y8_lane%0d", i), y8[i], ey8[i]);
        end
      end
    end
    if (done8) begin
      chk("done8_expected", qd8.size() != 0, 1);
      if (qd8.size() != 0) chk("done8_cyc", cyc, qd8.pop_front());
    end
    en8_p = en8;
  end
  int Am[2][2] = '{'{1, 2}, '{3, 4}};
  int Bm[2][2] = '{'{5, 6}, '{7, 8}};
  int X2[5][2] = '{'{1, 0}, '{2, 3}, '{0, 4}, '{0, 0}, '{0, 0}};
  int Y2[5][2] = '{'{5, 0}, '{7, 6}, '{0, 8}, '{0, 0}, '{0, 0}};
  task automatic run2(input int k, input int gap, input int lat, input int mode);
    fr2_t f, g;
    nclr2 = 0;
    nen2 = 0;
    nrdy2 = 0;
    for (int t = 0; t < 5 && k == 2; t++) begin
      f[0] = X2[t][0];
      f[1] = X2[t][1];
      g[0] = Y2[t][0];
      g[1] = Y2[t][1];
      qx2.push_back(f);
      qy2.push_back(g);
    end
    if (k == 2) begin
      qacc.push_back(19);
      qacc.push_back(22);
      qacc.push_back(43);
      qacc.push_back(50);
    end else
      repeat (4) qacc.push_back(0);
    qd2.push_back(cyc + lat);
    st2 = 1;
    kl2 = 9'(k);
    tick;
    st2 = 0;
    for (int b = 0; b < k; b++) begin
      for (int i = 0; i < 2; i++) begin
        a2[i] = Am[i][b];
        b2[i] = Bm[b][i];
      end
      v2 = 1;
      st2 = mode == 1 && b == 1;
      kl2 = mode == 1 ? 9'd1 : 9'(k);
      tick;
      v2 = 0;
      st2 = 0;
      a2 = '0;
      b2 = '0;
      if (b < k - 1) repeat (gap) tick;
    end
    if (mode == 2) begin
      tick;
      rst = 1;
      tick;
      rst = 0;
      qx2.delete();
      qy2.delete();
      qd2.delete();
      qacc.delete();
      repeat (12) tick;
    end else begin
      for (int t = 0; t < 40 && !done2; t++) begin
        st2 = mode == 1 && t == 1;
        tick;
      end
      st2 = 0;
      chk("done2_seen", done2, 1);
      tick;
      chk("clr2_count", nclr2, 1);
      chk("en2_count", nen2, k == 0 ? 0 : 5);
      if (k == 0) chk("rdy2_count", nrdy2, 0);
    end
  endtask
  logic [N-1:0] A8[8][256], B8[256][8];
  task automatic run8(input int kin, input int keff);
    fr8_t f, g;
    for (int b = 0; b < keff; b++)
      for (int i = 0; i < 8; i++) begin
        A8[i][b] = $urandom;
        B8[b][i] = $urandom;
      end
    A8[0][0] = 32'h8000_0000;
    B8[0][7] = 32'h8000_0000;
    A8[7][keff-1] = 32'h8000_0000;
    B8[keff-1][3] = 32'hFFFF_FFFF;
    for (int t = 0; t < keff + 15; t++) begin
      for (int i = 0; i < 8; i++) begin
        f[i] = '0;
        g[i] = '0;
        if (t - i >= 0 && t - i < keff) begin
          f[i] = A8[i][t-i];
          g[i] = B8[t-i][i];
        end
      end
      qx8.push_back(f);
      qy8.push_back(g);
    end
    qd8.push_back(cyc + 1 + keff + 15);
    st8 = 1;
    kl8 = 9'(kin);
    tick;
    st8 = 0;
    for (int b = 0; b < keff; b++) begin
      for (int i = 0; i < 8; i++) begin
        a8[i] = A8[i][b];
        b8[i] = B8[b][i];
      end
      v8 = 1;
      tick;
    end
    v8 = 0;
    a8 = '0;
    b8 = '0;
    for (int t = 0; t < 40 && !done8; t++) tick;
    chk("done8_seen", done8, 1);
    tick;
  endtask
  initial begin
    repeat (3) tick;
    rst = 0;
    chk("rst_x8", |x8, 0);
    chk("rst_y8", |y8, 0);
    chk("rst_rdy8", r8, 0);
    chk("rst_en8", en8, 0);
    chk("rst_clr8", clr8, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    tick;
    run2(2, 0, 6, 0);
    repeat (2) tick;
    run2(2, 3, 9, 0);
    repeat (2) tick;
    run2(0, 0, 1, 0);
    repeat (2) tick;
    run2(2, 0, 6, 1);
    repeat (2) tick;
    run2(2, 0, 6, 2);
    run2(2, 0, 6, 0);
    repeat (2) tick;
    run8(8, 8);
    repeat (2) tick;
    run8(511, 256);
    repeat (3) tick;
    chk("sb2_leftover", qx2.size() + qd2.size() + qacc.size(), 0);
    chk("sb8_leftover", qx8.size() + qd8.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
